multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multicycle RV32I control FSM. Sequences the shared-memory multicycle datapath (PC, IR, MDR, A/B, ALUOut registers; one ALU; one unified memory port) across FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK states.
- Subset covered: add, sub, and, or, slt, addi, lw, sw, beq, jal, jalr.
- Handles the memory ready handshake, a wait-timeout fault, an illegal-instruction fault and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16, max consecutive not-ready cycles in one memory wait state before fault (must be ≥1).
- CNT_W, 32, width of oRetired.

Ports:
- iCLK input 1: clock, rising edge.
- iRST input 1: asynchronous reset, active-high.
- iInstruction input 32: IR contents; valid from DECODE onward.
- iMemReady input 1: memory accepted the write / read data valid, this cycle.
- iZero input 1: ALU zero flag.
- oPCWrite output 1: unconditional PC load.
- oPCWriteCond output 1: PC load if iZero.
- oIorD output 1: mem address; 0=PC, 1=ALUOut.
- oMemRead output 1: memory read request.
- oMemWrite output 1: memory write request.
- oIRWrite output 1: IR load (MDR also loads every cycle).
- oRegWrite output 1: register file write.
- oMemtoReg output 2: 00 ALUOut, 01 MDR, 10 PC (already PC+4).
- oALUSrcA output 2: 00 PC, 01 A, 10 OldPC.
- oALUSrcB output 2: 00 B, 01 const 4, 10 Imm.
- oALUOp output 2: 00 add, 01 sub, 10 funct-decoded.
- oPCSource output 2: 00 ALU result, 01 ALUOut, 10 ALU result & ~1.
- oState output 4: current state encoding.
- oFault output 1: sticky fault flag.
- oFaultCause output 2: 00 none, 01 illegal, 10 timeout.
- oRetired output CNT_W: count of completed instructions.

Behaviour:
- Reset (async): state=FETCH, wait counter=0, oRetired=0, oFault=0, oFaultCause=00.
- Unlisted controls are 0. All controls are Moore except the FETCH IR/PC writes, which are gated by iMemReady.
- State encodings:
  - 0 FETCH: IorD=0, MemRead=1. If iMemReady: IRWrite=1, PCWrite=1, SrcA=00, SrcB=01, ALUOp=00, PCSource=00, go to DECODE; else stay.
  - 1 DECODE: SrcA=10, SrcB=10, ALUOp=00 (branch/jal target into ALUOut). Next state:
    - opcode 0110011 with {f7,f3} in {0000000/000, 0100000/000, 0000000/111, 0000000/110, 0000000/010} → EXEC_R.
    - 0010011 with f3=000 → EXEC_I.
    - 0000011 or 0100011 with f3=010 → MEM_ADDR.
    - 1100011 with f3=000 → BRANCH.
    - 1101111 → JAL.
    - 1100111 with f3=000 → JALR.
    - anything else → FAULT, cause 01.
  - 2 EXEC_R: SrcA=01, SrcB=00, ALUOp=10 → ALU_WB.
  - 3 EXEC_I: SrcA=01, SrcB=10, ALUOp=00 → ALU_WB.
  - 4 ALU_WB: RegWrite=1, MemtoReg=00 → FETCH.
  - 5 MEM_ADDR: SrcA=01, SrcB=10, ALUOp=00 → MEM_READ if opcode 0000011, else MEM_WRITE.
  - 6 MEM_READ: IorD=1, MemRead=1; on iMemReady → MEM_WB.
  - 7 MEM_WB: RegWrite=1, MemtoReg=01 → FETCH.
  - 8 MEM_WRITE: IorD=1, MemWrite=1; on iMemReady → FETCH.
  - 9 BRANCH: SrcA=01, SrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 → FETCH.
  - 10 JAL: RegWrite=1, MemtoReg=10, PCWrite=1, PCSource=01 → FETCH.
  - 11 JALR: SrcA=01, SrcB=10, ALUOp=00, PCWrite=1, PCSource=10, RegWrite=1, MemtoReg=10 → FETCH. rs1 is read from the A register, so rd==rs1 is safe.
  - 12 FAULT: all controls 0; stays until reset.
- Retirement: oRetired increments by 1 (wraps at 2^CNT_W) on every transition into FETCH from states 4, 7, 8, 9, 10, 11. It never increments on entry to FAULT.
- Latencies with iMemReady always 1:
  - R-type/addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/jal/jalr: 3 cycles.
  - Each not-ready cycle in FETCH/MEM_READ/MEM_WRITE adds 1 cycle.
- Wait counter:
  - Clears on every state change.
  - Increments each cycle spent in a wait state with iMemReady=0.
  - If the counter reaches MEM_TIMEOUT, the next state is FAULT with cause 10.
  - iMemReady in the same cycle the counter reaches MEM_TIMEOUT wins: normal transition.
- oFaultCause latches on FAULT entry and holds until reset.
- Reset mid-operation: immediate return to FETCH. No partial RegWrite/MemWrite is asserted after iRST rises.
- oState reflects the registered state.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093), iMemReady=1 → oState 0,1,3,4,0; RegWrite=1 only in state 4; oRetired=1.
- lw (0x0000A103) with iMemReady low for 3 cycles in MEM_READ → stays in state 6 for 4 cycles with IorD=1, MemRead=1; total 8 cycles; MemtoReg=01 in state 7.
- beq x1,x2 (0x00208463) → state 9 with PCWriteCond=1, PCSource=01, ALUOp=01; completes in 3 cycles regardless of iZero.
- jalr (0x000080E7) → state 11 with PCWrite=1, PCSource=10, RegWrite=1, MemtoReg=10; oRetired increments.
- Illegal 0xFFFFFFFF → DECODE→FAULT; oFault=1, oFaultCause=01; remains in FAULT with all controls 0 for 20 cycles; oRetired unchanged.
- iMemReady=0 held in FETCH with MEM_TIMEOUT=16 → FAULT after 16 wait cycles, oFaultCause=10. Then assert iRST mid-MEM_WRITE on a second run → oState=0, MemWrite=0 immediately, counters cleared.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM driving a shared-memory PC/IR/MDR/A/B/ALUOut datapath.
// 3-5 cycles per instruction; FETCH/MEM_READ/MEM_WRITE stretch while iMemReady=0 and fault after MEM_TIMEOUT waits.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [31:0]      iInstruction,
    input  logic             iMemReady,
    input  logic             iZero,
    output logic             oPCWrite,
    output logic             oPCWriteCond,
    output logic             oIorD,
    output logic             oMemRead,
    output logic             oMemWrite,
    output logic             oIRWrite,
    output logic             oRegWrite,
    output logic [1:0]       oMemtoReg,
    output logic [1:0]       oALUSrcA,
    output logic [1:0]       oALUSrcB,
    output logic [1:0]       oALUOp,
    output logic [1:0]       oPCSource,
    output logic [3:0]       oState,
    output logic             oFault,
    output logic [1:0]       oFaultCause,
    output logic [CNT_W-1:0] oRetired
);
    localparam int                WCNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_ALU_WB    = 4'd4,
        S_MEM_ADDR  = 4'd5,
        S_MEM_READ  = 4'd6,
        S_MEM_WB    = 4'd7,
        S_MEM_WRITE = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_FAULT     = 4'd12
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              fault_q, fault_d;
    logic [1:0]        cause_q, cause_d;
    logic [1:0]        new_cause;
    logic              in_wait;
    logic [6:0]        opcode;
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic              r_legal;
    logic              timed_out;
    logic              unused_bits;

    assign opcode      = iInstruction[6:0];
    assign funct3      = iInstruction[14:12];
    assign funct7      = iInstruction[31:25];
    // iZero is consumed by the PC-write logic outside this block.
    assign unused_bits = ^{iZero, iInstruction[24:15], iInstruction[11:7]};

    // add, sub, and, or, slt
    assign r_legal   = (funct3 == 3'b000 && (funct7 == 7'h00 || funct7 == 7'h20)) ||
                       (funct7 == 7'h00 && (funct3 == 3'b111 || funct3 == 3'b110 || funct3 == 3'b010));
    // A ready response in the cycle the count hits the limit still completes normally.
    assign timed_out = (wcnt_q >= TIMEOUT_V);

    always_comb begin
        state_d      = state_q;
        new_cause    = 2'b00;
        in_wait      = 1'b0;
        oPCWrite     = 1'b0;
        oPCWriteCond = 1'b0;
        oIorD        = 1'b0;
        oMemRead     = 1'b0;
        oMemWrite    = 1'b0;
        oIRWrite     = 1'b0;
        oRegWrite    = 1'b0;
        oMemtoReg    = 2'b00;
        oALUSrcA     = 2'b00;
        oALUSrcB     = 2'b00;
        oALUOp       = 2'b00;
        oPCSource    = 2'b00;

        case (state_q)
            S_FETCH: begin
                in_wait  = 1'b1;
                oMemRead = 1'b1;
                oALUSrcB = 2'b01;
                if (iMemReady) begin
                    oIRWrite = 1'b1;
                    oPCWrite = 1'b1;
                    state_d  = S_DECODE;
                end else if (timed_out) begin
                    state_d   = S_FAULT;
                    new_cause = 2'b10;
                end
            end
            S_DECODE: begin
                oALUSrcA = 2'b10;
                oALUSrcB = 2'b10;
                case (opcode)
                    7'b0110011:             state_d = r_legal ? S_EXEC_R : S_FAULT;
                    7'b0010011:             state_d = (funct3 == 3'b000) ? S_EXEC_I : S_FAULT;
                    7'b0000011, 7'b0100011: state_d = (funct3 == 3'b010) ? S_MEM_ADDR : S_FAULT;
                    7'b1100011:             state_d = (funct3 == 3'b000) ? S_BRANCH : S_FAULT;
                    7'b1101111:             state_d = S_JAL;
                    7'b1100111:             state_d = (funct3 == 3'b000) ? S_JALR : S_FAULT;
                    default:                state_d = S_FAULT;
                endcase
                if (state_d == S_FAULT) new_cause = 2'b01;
            end
            S_EXEC_R: begin
                oALUSrcA = 2'b01;
                oALUOp   = 2'b10;
                state_d  = S_ALU_WB;
            end
            S_EXEC_I: begin
                oALUSrcA = 2'b01;
                oALUSrcB = 2'b10;
                state_d  = S_ALU_WB;
            end
            S_ALU_WB: begin
                oRegWrite = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                oALUSrcA = 2'b01;
                oALUSrcB = 2'b10;
                state_d  = (opcode == 7'b0000011) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                in_wait  = 1'b1;
                oIorD    = 1'b1;
                oMemRead = 1'b1;
                if (iMemReady) begin
                    state_d = S_MEM_WB;
                end else if (timed_out) begin
                    state_d   = S_FAULT;
                    new_cause = 2'b10;
                end
            end
            S_MEM_WB: begin
                oRegWrite = 1'b1;
                oMemtoReg = 2'b01;
                state_d   = S_FETCH;
            end
            S_MEM_WRITE: begin
                in_wait   = 1'b1;
                oIorD     = 1'b1;
                oMemWrite = 1'b1;
                if (iMemReady) begin
                    state_d = S_FETCH;
                end else if (timed_out) begin
                    state_d   = S_FAULT;
                    new_cause = 2'b10;
                end
            end
            S_BRANCH: begin
                oALUSrcA     = 2'b01;
                oALUOp       = 2'b01;
                oPCWriteCond = 1'b1;
                oPCSource    = 2'b01;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                oRegWrite = 1'b1;
                oMemtoReg = 2'b10;
                oPCWrite  = 1'b1;
                oPCSource = 2'b01;
                state_d   = S_FETCH;
            end
            S_JALR: begin
                oALUSrcA  = 2'b01;
                oALUSrcB  = 2'b10;
                oPCWrite  = 1'b1;
                oPCSource = 2'b10;
                oRegWrite = 1'b1;
                oMemtoReg = 2'b10;
                state_d   = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase

        if (state_d != state_q) begin
            wcnt_d = '0;
        end else if (in_wait && !iMemReady) begin
            wcnt_d = wcnt_q + WCNT_W'(1);
        end else begin
            wcnt_d = wcnt_q;
        end

        retired_d = retired_q;
        if (state_d == S_FETCH &&
            state_q inside {S_ALU_WB, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JAL, S_JALR}) begin
            retired_d = retired_q + CNT_W'(1);
        end

        fault_d = fault_q;
        cause_d = cause_q;
        if (state_d == S_FAULT && state_q != S_FAULT) begin
            fault_d = 1'b1;
            cause_d = new_cause;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= S_FETCH;
            wcnt_q    <= '0;
            retired_q <= '0;
            fault_q   <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
            cause_q   <= cause_d;
        end
    end

    assign oState      = state_q;
    assign oFault      = fault_q;
    assign oFaultCause = cause_q;
    assign oRetired    = retired_q;
endmodule
